// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/busy/done handshake plus operand and result bus for the divider
//   start, dividend, divisor : controller -> divider
//   quotient, remainder      : divider -> controller, held until the next completion
//   busy, done, div_by_zero  : divider -> controller status
interface restoring_divider_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic busy;
  logic done;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero);
  modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient bit per clock, MSB first
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, aborts any division in flight
//   bus   : slave side of restoring_divider_if (start/operands in, results/status out)
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  logic [1:0] state;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] nrem;
  logic ok;
  logic acc;
  assign acc = bus.start && (state == IDLE || state == DONE);
  assign sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  // remainder + ~divisor + 1 on the low bits; a set top bit of the shifted
  // remainder stands in for a carry, so the trial can never borrow then
  assign sum = {1'b0, sh[WIDTH-1:0]} + {1'b0, ~dvs} + ONE;
  assign ok = sh[WIDTH] | sum[WIDTH];
  assign nrem = ok ? {1'b0, sum[WIDTH-1:0]} : sh;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      cnt <= '0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (acc) begin
      dvd <= bus.dividend;
      dvs <= bus.divisor;
      rem <= '0;
      cnt <= '0;
      state <= bus.divisor == '0 ? DONE : RUN;
      if (bus.divisor == '0) begin
        bus.quotient <= '1;
        bus.remainder <= bus.dividend;
        bus.div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      rem <= nrem;
      dvd <= {dvd[WIDTH-2:0], ok};
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        state <= DONE;
        bus.quotient <= {dvd[WIDTH-2:0], ok};
        bus.remainder <= nrem[WIDTH-1:0];
        bus.div_by_zero <= 1'b0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and model-checked stimulus for restoring_divider
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  restoring_divider_if #(.WIDTH(8)) bus();
  restoring_divider #(.WIDTH(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er, input string tag);
    int n;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    if (b != 8'd0) check({tag, " busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, b == 8'd0 ? 32'd0 : 32'd8);
    check({tag, " q"}, 32'(bus.quotient), 32'(eq));
    check({tag, " r"}, 32'(bus.remainder), 32'(er));
    check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(b == 8'd0));
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " done width"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    int pulses;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] sr;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
    repeat (2) @(negedge clk);
    check("reset q", 32'(bus.quotient), 32'd0);
    check("reset r", 32'(bus.remainder), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'd200, 8'd7, 8'd28, 8'd4, "200/7");
    repeat (4) @(negedge clk);
    check("hold q", 32'(bus.quotient), 32'd28);
    check("hold r", 32'(bus.remainder), 32'd4);
    check("hold done", 32'(bus.done), 32'd0);
    run(8'd255, 8'd1, 8'd255, 8'd0, "255/1");
    run(8'd5, 8'd9, 8'd0, 8'd5, "5/9");
    run(8'd255, 8'd255, 8'd1, 8'd0, "255/255");
    run(8'd254, 8'd128, 8'd1, 8'd126, "254/128");
    run(8'd0, 8'd13, 8'd0, 8'd0, "0/13");
    run(8'h80, 8'd0, 8'hFF, 8'h80, "128/0");
    run(8'd10, 8'd3, 8'd3, 8'd1, "10/3");
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 8'd77;
    bus.divisor = 8'd3;
    pulses = 0;
    sq = 8'd0;
    sr = 8'd0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) begin
        pulses++;
        sq = bus.quotient;
        sr = bus.remainder;
      end
      @(negedge clk);
    end
    check("ignore start pulses", pulses, 32'd1);
    check("ignore start q", 32'(sq), 32'd10);
    check("ignore start r", 32'(sr), 32'd0);
    bus.start = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort q", 32'(bus.quotient), 32'd0);
    check("abort r", 32'(bus.remainder), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort dbz", 32'(bus.div_by_zero), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    check("abort no done", pulses, 32'd0);
    run(8'd77, 8'd5, 8'd15, 8'd2, "77/5");
    bus.start = 1'b1;
    bus.dividend = 8'd60;
    bus.divisor = 8'd7;
    @(negedge clk);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", n, 32'd8);
    check("b2b first q", 32'(bus.quotient), 32'd8);
    check("b2b first r", 32'(bus.remainder), 32'd4);
    bus.dividend = 8'd9;
    bus.divisor = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    check("b2b accept busy", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b gap", n, 32'd9);
    check("b2b second q", 32'(bus.quotient), 32'd2);
    check("b2b second r", 32'(bus.remainder), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        sq = 8'hFF;
        sr = a;
      end else begin
        sq = a / b;
        sr = a % b;
      end
      run(a, b, sq, sr, "random");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse operation to the team's Booth multiplier in the arithmetic unit.
- Computes quotient and remainder of dividend/divisor, one bit per clock, MSB first.
- The trial subtraction is done through the existing 8-bit CLA adder as remainder + ~divisor + 1. Carry-out = 1 means no borrow, so the trial result is kept.
- Sits beside the multiplier and is driven by the ALU controller through a start/busy/done handshake.

Parameters:
- WIDTH, 8: operand, quotient and remainder width. Iteration count equals WIDTH. Only 8 is verified; the adder instance is 8-bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  numerator; captured on the accepting edge
- divisor  input  WIDTH  denominator; captured on the accepting edge
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  sticky error flag for the last division

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state:
  - state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0
  - iteration counter=0, internal operand registers=0
- Reset mid-operation aborts the operation. No done pulse is generated.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor!=0 latches dividend and divisor, clears the partial remainder and counter, and goes to RUN.
  - start=1 with divisor=0 goes to DONE.
  - start=0 stays in IDLE.
- RUN, one iteration per edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial = shifted remainder − divisor, computed via the adder with Cin=1 and B inverted.
  - If adder Cout=1: remainder ← trial and quotient bit ← 1. Else: remainder is kept and quotient bit ← 0.
  - Counter increments. When the counter reaches WIDTH−1 and that iteration completes, go to DONE.
- Partial remainder must hold one extra bit (WIDTH+1) internally so that divisors ≥ 0x80 are correct. The upper-bit handling must match the adder carry semantics.
- DONE, one cycle:
  - done=1. quotient and remainder are updated with the final values.
  - Next state is IDLE, or RUN/DONE directly if start=1 on this edge (back-to-back accept).
- Latency:
  - Normal case: done is high in the cycle beginning WIDTH+1 edges after the accepting edge.
  - Divide by zero: done is high in the cycle beginning 1 edge after the accepting edge.
- busy=1 in RUN only. It is high from the edge after acceptance until DONE is entered. busy=0 in DONE and IDLE.
- start while in RUN is ignored. Operand input changes during RUN have no effect.
- quotient and remainder hold their last values through IDLE until the next DONE. They do not glitch during RUN; internal working registers are separate from the outputs.
- Divide by zero: quotient=all ones (0xFF), remainder=dividend, div_by_zero=1.
- div_by_zero is updated on every DONE entry: set on a zero divisor, cleared on a valid divide. It holds otherwise.
- Results are exact unsigned: dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- 200/7: start one cycle -> busy for 8 cycles, then done pulse with quotient=28 (0x1C), remainder=4, div_by_zero=0; outputs hold 4 idle cycles later.
- Boundary values:
  - 255/1 -> q=255, r=0.
  - 5/9 -> q=0, r=5.
  - 255/255 -> q=1, r=0.
  - 254/128 -> q=1, r=126.
  - 0/13 -> q=0, r=0.
- 0x80/0 -> done on the second cycle after start; q=0xFF, r=0x80, div_by_zero=1. A following 10/3 gives q=3, r=1 and clears div_by_zero.
- Start 100/10, then pulse start with 9/2 at the 3rd busy cycle and change operand inputs -> ignored; result q=10, r=0, exactly one done pulse.
- Start 77/5, assert rst_n=0 for one edge at the 4th busy cycle -> all outputs 0 and no done pulse. A new start 77/5 then gives q=15, r=2.
- Hold start high with 60/7 then 9/4 back-to-back, changing operands in the DONE cycle -> first done q=8, r=4; second accepted in that DONE cycle, done 9 cycles later with q=2, r=1. Random sweep of 1000 pairs checked against a reference model.
